// File: rtl/omsp_per_master.sv
// Peripheral-bus initiator for the openMSP430: converts request/response transactions
// into per_* bus cycles, yielding to the CPU whenever it owns the shared bus.
module omsp_per_master #(
   parameter int PER_AW = 9,
   parameter int LEN_W  = 4
) (
   input  logic             mclk,
   input  logic             puc,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [15:0]      req_addr,
   input  logic             req_wr,
   input  logic             req_byte,
   input  logic [15:0]      req_wdata,
   input  logic [LEN_W-1:0] req_len,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [15:0]      rsp_rdata,
   output logic             rsp_err,
   output logic             rsp_last,
   input  logic             cpu_per_en,
   output logic [7:0]       per_addr,
   output logic [15:0]      per_din,
   output logic             per_en,
   output logic [1:0]       per_we,
   input  logic [15:0]      per_dout,
   output logic [1:0]       fsm_state
);

   // Handshakes: a transfer happens on the mclk edge where valid and ready are both 1;
   // valid and its payload stay stable until then, ready may change freely.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      addr_q;
   logic             wr_q;
   logic             byte_q;
   logic [15:0]      wdata_q;
   logic [LEN_W-1:0] rem_q;
   logic             err_q;
   logic [15:0]      rdata_q;

   logic             accept;
   logic             beat_done;
   logic             rsp_hs;
   logic             last;
   logic [15:0]      next_addr;
   logic [15:0]      rd_capture;

   function automatic logic out_of_space(input logic [15:0] a);
      return (a >> PER_AW) != 16'd0;
   endfunction

   assign fsm_state = state_q;
   assign last      = (rem_q == '0) | err_q;
   assign next_addr = addr_q + (byte_q ? 16'd1 : 16'd2);
   assign rd_capture = byte_q ? {8'h00, (addr_q[0] ? per_dout[15:8] : per_dout[7:0])}
                              : per_dout;

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = 16'h0000;
      rsp_err   = 1'b0;
      rsp_last  = 1'b0;
      per_addr  = 8'h00;
      per_din   = 16'h0000;
      per_en    = 1'b0;
      per_we    = 2'b00;
      accept    = 1'b0;
      beat_done = 1'b0;
      rsp_hs    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               state_d = out_of_space(req_addr) ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            // Bus outputs come only from registers so they hold steady through CPU stalls.
            per_addr = addr_q[8:1];
            per_din  = byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;
            if (wr_q) begin
               per_we = byte_q ? (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
            end
            per_en = ~cpu_per_en;
            if (!cpu_per_en) begin
               beat_done = 1'b1;
               state_d   = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_rdata = rdata_q;
            rsp_err   = err_q;
            rsp_last  = last;
            if (rsp_ready) begin
               rsp_hs = 1'b1;
               if (last) begin
                  state_d = IDLE;
               end else begin
                  state_d = out_of_space(next_addr) ? RESP : ACCESS;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mclk or posedge puc) begin
      if (puc) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge mclk or posedge puc) begin
      if (puc) begin
         addr_q  <= 16'h0000;
         wr_q    <= 1'b0;
         byte_q  <= 1'b0;
         wdata_q <= 16'h0000;
         rem_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= 16'h0000;
      end else begin
         if (accept) begin
            addr_q  <= req_addr;
            wr_q    <= req_wr;
            byte_q  <= req_byte;
            wdata_q <= req_wdata;
            rem_q   <= req_wr ? '0 : req_len;
            err_q   <= out_of_space(req_addr);
            rdata_q <= 16'h0000;
         end
         if (beat_done) begin
            rdata_q <= wr_q ? 16'h0000 : rd_capture;
         end
         // Burst advance; leaving peripheral space turns the next beat into a terminal error.
         if (rsp_hs && !last) begin
            rem_q   <= rem_q - LEN_W'(1);
            addr_q  <= next_addr;
            err_q   <= out_of_space(next_addr);
            rdata_q <= 16'h0000;
         end
      end
   end

endmodule

// File: tb/tb_omsp_per_master.sv
// Bench for omsp_per_master: shadow-memory transaction model feeding expected queues,
// a per-cycle compare process, directed scenarios with literal values, then random traffic.
module tb_omsp_per_master;

   localparam int LEN_W = 4;

   logic             mclk = 1'b0;
   logic             puc = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [15:0]      req_addr = 16'h0;
   logic             req_wr = 1'b0;
   logic             req_byte = 1'b0;
   logic [15:0]      req_wdata = 16'h0;
   logic [LEN_W-1:0] req_len = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [15:0]      rsp_rdata;
   logic             rsp_err;
   logic             rsp_last;
   logic             cpu_per_en = 1'b0;
   logic [7:0]       per_addr;
   logic [15:0]      per_din;
   logic             per_en;
   logic [1:0]       per_we;
   logic [15:0]      per_dout;
   logic [1:0]       fsm_state;

   omsp_per_master #(.PER_AW(9), .LEN_W(LEN_W)) dut (
      .mclk(mclk), .puc(puc),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wr(req_wr), .req_byte(req_byte), .req_wdata(req_wdata), .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_last(rsp_last), .cpu_per_en(cpu_per_en),
      .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we),
      .per_dout(per_dout), .fsm_state(fsm_state)
   );

   // ---------------- clock / reset ----------------
   always #5 mclk = ~mclk;

   // ---------------- peripheral + shadow memories ----------------
   logic [15:0] pmem[256];
   logic [15:0] shadow[256];
   assign per_dout = pmem[per_addr];

   always @(posedge mclk) begin
      if (!puc && per_en) begin
         if (per_we[0]) pmem[per_addr][7:0] = per_din[7:0];
         if (per_we[1]) pmem[per_addr][15:8] = per_din[15:8];
      end
   end

   // ---------------- scoreboard state ----------------
   logic [25:0] exp_bus_q[$];   // {word_addr, we, din}
   logic [17:0] exp_rsp_q[$];   // {err, last, rdata}
   int n_checks = 0;
   int n_pass = 0;
   int en_count = 0;
   int rsp_count = 0;
   int last_cnt = 0;
   logic [7:0]  last_bus_addr = 8'h0;
   logic [1:0]  last_bus_we = 2'b0;
   logic [15:0] last_bus_din = 16'h0;
   logic [15:0] last_rdata = 16'h0;
   logic        last_err = 1'b0;
   logic        last_last = 1'b0;
   logic        busy = 1'b0;
   logic        prev_en = 1'b0;
   int rdy_mode = 0;   // 0 always ready, 1 random, 2 never, 3 hold off 3 cycles per response
   int cpu_mode = 0;   // 0 idle, 1 random, 2 always busy
   int hold_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
   endtask

   // Transaction model: expands one request into expected bus beats and responses.
   function automatic int model_req(input logic [15:0] a0, input logic wr, input logic is_byte,
                                    input logic [15:0] wd, input int len);
      int n;
      int cnt;
      logic [15:0] a;
      logic [7:0] wa;
      logic [1:0] we;
      logic [15:0] din;
      logic [15:0] rd;
      logic [15:0] w;
      n = wr ? 1 : len + 1;
      cnt = 0;
      a = a0;
      for (int i = 0; i < n; i++) begin
         if (a >= 16'h0200) begin
            exp_rsp_q.push_back({1'b1, 1'b1, 16'h0000});
            cnt++;
            break;
         end
         wa = 8'(a >> 1);
         if (wr) begin
            we  = is_byte ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
            din = is_byte ? {wd[7:0], wd[7:0]} : wd;
            if (we[0]) shadow[wa][7:0] = din[7:0];
            if (we[1]) shadow[wa][15:8] = din[15:8];
            rd = 16'h0000;
         end else begin
            we  = 2'b00;
            din = 16'h0000;
            w   = shadow[wa];
            rd  = is_byte ? (a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]}) : w;
         end
         exp_bus_q.push_back({wa, we, din});
         exp_rsp_q.push_back({1'b0, (i == n - 1), rd});
         cnt++;
         a = a + (is_byte ? 16'd1 : 16'd2);
      end
      return cnt;
   endfunction

   // ---------------- background drivers ----------------
   always @(posedge mclk) begin
      #1;
      hold_cnt = rsp_valid ? hold_cnt + 1 : 0;
      case (rdy_mode)
         0: rsp_ready = 1'b1;
         1: rsp_ready = 1'($urandom_range(0, 1));
         2: rsp_ready = 1'b0;
         default: rsp_ready = (hold_cnt > 3);
      endcase
      case (cpu_mode)
         0: cpu_per_en = 1'b0;
         1: cpu_per_en = ($urandom_range(0, 9) < 3);
         default: cpu_per_en = 1'b1;
      endcase
   end

   // ---------------- compare process ----------------
   always @(negedge mclk) begin
      logic [25:0] eb;
      logic [17:0] er;
      if (puc) begin
         chk("rst_req_ready", req_ready, 1);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_per_en", per_en, 0);
         busy = 1'b0;
         prev_en = 1'b0;
      end else begin
         chk("req_ready_vs_busy", req_ready, !busy);
         if (cpu_per_en) chk("per_en_under_cpu", per_en, 0);
         if (prev_en) chk("beat_to_rsp_latency", rsp_valid, 1);
         if (!busy) begin
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_per_en", per_en, 0);
         end
         if (per_en) begin
            if (exp_bus_q.size() == 0) begin
               chk("unexpected_bus_beat", per_addr, 32'hFFFF_FFFF);
            end else begin
               eb = exp_bus_q.pop_front();
               chk("bus_addr", per_addr, eb[25:18]);
               chk("bus_we", per_we, eb[17:16]);
               if (eb[17:16] != 2'b00) chk("bus_din", per_din, eb[15:0]);
            end
            last_bus_addr = per_addr;
            last_bus_we = per_we;
            last_bus_din = per_din;
            en_count++;
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_rsp_q.size() == 0) begin
               chk("unexpected_rsp", rsp_rdata, 32'hFFFF_FFFF);
            end else begin
               er = exp_rsp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, er[15:0]);
               chk("rsp_err", rsp_err, er[17]);
               chk("rsp_last", rsp_last, er[16]);
               if (er[16]) busy = 1'b0;
            end
            last_rdata = rsp_rdata;
            last_err = rsp_err;
            last_last = rsp_last;
            if (rsp_last) last_cnt++;
            rsp_count++;
         end
         if (req_valid && req_ready) busy = 1'b1;
         prev_en = per_en;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [15:0] a, input logic wr, input logic is_byte,
                        input logic [15:0] wd, input int len, output int nrsp);
      bit ok;
      nrsp = model_req(a, wr, is_byte, wd, len);
      req_addr = a;
      req_wr = wr;
      req_byte = is_byte;
      req_wdata = wd;
      req_len = LEN_W'(len);
      req_valid = 1'b1;
      ok = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge mclk);
         if (req_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge mclk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      bit ok;
      ok = 0;
      for (int k = 0; k < 1000; k++) begin
         @(posedge mclk);
         if (rsp_count >= target) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("rsp_timeout", rsp_count, target);
      #1;
   endtask

   task automatic do_req(input logic [15:0] a, input logic wr, input logic is_byte,
                         input logic [15:0] wd, input int len);
      int start;
      int n;
      start = rsp_count;
      issue(a, wr, is_byte, wd, len, n);
      wait_rsp(start + n);
   endtask

   task automatic apply_reset();
      @(posedge mclk);
      #1 puc = 1'b1;
      req_valid = 1'b0;
      exp_bus_q.delete();
      exp_rsp_q.delete();
      @(negedge mclk);
      chk("puc_rsp_valid", rsp_valid, 0);
      chk("puc_per_en", per_en, 0);
      chk("puc_req_ready", req_ready, 1);
      @(posedge mclk);
      #1 puc = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int e0;
      int r0;
      int l0;
      int n;
      int start;
      bit ok;
      logic [15:0] a;
      for (int i = 0; i < 256; i++) begin
         pmem[i] = 16'($urandom);
         shadow[i] = pmem[i];
      end
      pmem[8'h2C] = 16'h1234;
      shadow[8'h2C] = 16'h1234;
      pmem[8'h30] = 16'hBEEF;
      shadow[8'h30] = 16'hBEEF;

      repeat (3) @(posedge mclk);
      @(negedge mclk);
      chk("reset_req_ready", req_ready, 1);
      chk("reset_per_we", per_we, 0);
      chk("reset_rsp_rdata", rsp_rdata, 0);
      chk("reset_rsp_err", rsp_err, 0);
      chk("reset_state_idle", fsm_state, 0);
      @(posedge mclk);
      #1 puc = 1'b0;
      repeat (2) @(posedge mclk);
      #1;

      // Word read 0x0058
      e0 = en_count;
      do_req(16'h0058, 1'b0, 1'b0, 16'h0000, 0);
      chk("wr58_rdata", last_rdata, 16'h1234);
      chk("wr58_last", last_last, 1);
      chk("wr58_en_cycles", en_count - e0, 1);
      chk("wr58_we", last_bus_we, 2'b00);
      chk("wr58_addr", last_bus_addr, 8'h2C);

      // Byte write 0x0057 <- 0xA5
      do_req(16'h0057, 1'b1, 1'b1, 16'h00A5, 0);
      chk("bw57_addr", last_bus_addr, 8'h2B);
      chk("bw57_we", last_bus_we, 2'b10);
      chk("bw57_din", last_bus_din, 16'hA5A5);
      chk("bw57_err", last_err, 0);
      chk("bw57_rdata", last_rdata, 0);
      chk("bw57_mem_hi", pmem[8'h2B][15:8], 8'hA5);

      // Burst read 0x0056 len=2 with slow consumer
      rdy_mode = 3;
      e0 = en_count;
      r0 = rsp_count;
      l0 = last_cnt;
      do_req(16'h0056, 1'b0, 1'b0, 16'h0000, 2);
      chk("burst_en_cycles", en_count - e0, 3);
      chk("burst_rsp_count", rsp_count - r0, 3);
      chk("burst_last_count", last_cnt - l0, 1);
      chk("burst_final_addr", last_bus_addr, 8'h2D);
      rdy_mode = 0;

      // CPU owns the bus for 5 cycles during ACCESS
      cpu_mode = 2;
      @(posedge mclk);
      #2;
      e0 = en_count;
      start = rsp_count;
      issue(16'h0060, 1'b0, 1'b0, 16'h0000, 0, n);
      repeat (5) @(posedge mclk);
      chk("stall_no_en", en_count - e0, 0);
      cpu_mode = 0;
      wait_rsp(start + n);
      chk("stall_en_cycles", en_count - e0, 1);
      chk("stall_rdata", last_rdata, 16'hBEEF);

      // Out-of-space and edge-of-space burst
      e0 = en_count;
      do_req(16'h0200, 1'b0, 1'b0, 16'h0000, 0);
      chk("oob_en_cycles", en_count - e0, 0);
      chk("oob_err", last_err, 1);
      chk("oob_last", last_last, 1);
      chk("oob_rdata", last_rdata, 0);
      e0 = en_count;
      r0 = rsp_count;
      do_req(16'h01FE, 1'b0, 1'b0, 16'h0000, 1);
      chk("edge_en_cycles", en_count - e0, 1);
      chk("edge_rsp_count", rsp_count - r0, 2);
      chk("edge_err", last_err, 1);
      chk("edge_last", last_last, 1);

      // Reset while in RESP
      rdy_mode = 2;
      issue(16'h0010, 1'b0, 1'b0, 16'h0000, 0, n);
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge mclk);
         if (rsp_valid) begin
            ok = 1;
            break;
         end
      end
      chk("resp_reached", ok, 1);
      apply_reset();
      rdy_mode = 0;
      do_req(16'h0058, 1'b0, 1'b0, 16'h0000, 0);
      chk("after_rst1_rdata", last_rdata, 16'h1234);

      // Reset while stalled in ACCESS
      cpu_mode = 2;
      @(posedge mclk);
      #2;
      e0 = en_count;
      issue(16'h0060, 1'b1, 1'b0, 16'h5555, 0, n);
      repeat (2) @(posedge mclk);
      apply_reset();
      chk("access_rst_no_en", en_count - e0, 0);
      cpu_mode = 0;
      shadow[8'h30] = pmem[8'h30];
      do_req(16'h0060, 1'b0, 1'b0, 16'h0000, 0);
      chk("after_rst2_rdata", last_rdata, 16'hBEEF);

      // Randomized traffic
      rdy_mode = 1;
      cpu_mode = 1;
      for (int t = 0; t < 80; t++) begin
         case ($urandom_range(0, 9))
            0: a = 16'($urandom);
            1: a = 16'($urandom_range(16'h01F0, 16'h01FF));
            default: a = 16'($urandom_range(0, 16'h01FF));
         endcase
         do_req(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom), $urandom_range(0, 5));
      end
      rdy_mode = 0;
      cpu_mode = 0;
      repeat (3) @(posedge mclk);
      #1;
      chk("bus_queue_drained", exp_bus_q.size(), 0);
      chk("rsp_queue_drained", exp_rsp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
